// File: rtl/calc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : calc_alu_seq
// Purpose  : Multi-cycle unsigned arithmetic unit for the calculator datapath.
//            Add/subtract finish in one cycle. Multiply is an iterative
//            shift-add that takes WIDTH cycles. Divide, when enabled, is an
//            iterative restoring divide that also takes WIDTH cycles.
//            The block uses a start/done handshake.
// Options  : CALC_ALU_DIV_EN - when defined, op 11 is an unsigned divide.
//            When undefined, op 11 completes in one cycle with err=1, and
//            the divider state and datapath are not built.
// Ports    : clk        - rising-edge clock
//            clear_n    - asynchronous reset, active low
//            start      - request, accepted while busy=0
//            op_sel     - 00 add, 01 sub, 10 mul, 11 div
//            num1, num2 - WIDTH-bit unsigned operands
//            busy       - high while an iterative operation is running
//            done       - one-cycle completion pulse
//            number_out - 2*WIDTH-bit result
//            carry      - add carry / subtract borrow, 0 for mul/div
//            err        - illegal op or divide-by-zero on last completion
// Revision : 1.0 - initial release
// ============================================================================
module calc_alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [1:0]           op_sel,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   number_out,
    output logic                 carry,
    output logic                 err
);

    localparam int         CNT_W  = 5;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 err_q, err_d;

    // Multiplier datapath: multiplicand shifts left, multiplier shifts right
    // so that bit 0 always selects the current partial product.
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_acc_next;

`ifdef CALC_ALU_DIV_EN
    // Restoring divider: quo_q starts as the dividend and is shifted out MSB
    // first into the partial remainder while quotient bits shift in at LSB.
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dsor_q, dsor_d;
    logic                 divz_q, divz_d;
    logic [WIDTH:0]       w_rem_shift;
    logic [WIDTH:0]       w_trial;
    logic                 w_fits;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    // With a zero divisor every trial subtraction fits, which naturally
    // yields an all-ones quotient and a remainder equal to the dividend.
    always_comb begin
        w_rem_shift = {rem_q, quo_q[WIDTH-1]};
        w_trial     = w_rem_shift - {1'b0, dsor_q};
        w_fits      = (w_rem_shift >= {1'b0, dsor_q});
        w_rem_next  = w_fits ? w_trial[WIDTH-1:0] : w_rem_shift[WIDTH-1:0];
        w_quo_next  = {quo_q[WIDTH-2:0], w_fits};
    end
`endif

    assign w_sum      = {1'b0, num1} + {1'b0, num2};
    assign w_diff     = {1'b0, num1} - {1'b0, num2};
    assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        err_d    = err_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
`ifdef CALC_ALU_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsor_d   = dsor_q;
        divz_d   = divz_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op_sel)
                        2'b00: begin
                            result_d = {{(WIDTH-1){1'b0}}, w_sum};
                            carry_d  = w_sum[WIDTH];
                            err_d    = 1'b0;
                            done_d   = 1'b1;
                        end
                        2'b01: begin
                            result_d = {{(WIDTH-1){1'b0}}, w_diff};
                            carry_d  = w_diff[WIDTH];
                            err_d    = 1'b0;
                            done_d   = 1'b1;
                        end
                        2'b10: begin
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            mcand_d  = {{WIDTH{1'b0}}, num1};
                            mplier_d = num2;
                            acc_d    = '0;
                        end
                        default: begin
`ifdef CALC_ALU_DIV_EN
                            state_d  = S_DIV;
                            cnt_d    = '0;
                            rem_d    = '0;
                            quo_d    = num1;
                            dsor_d   = num2;
                            divz_d   = (num2 == '0);
`else
                            result_d = '0;
                            carry_d  = 1'b0;
                            err_d    = 1'b1;
                            done_d   = 1'b1;
`endif
                        end
                    endcase
                end
            end

            S_MUL: begin
                acc_d    = w_acc_next;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    result_d = w_acc_next;
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end

`ifdef CALC_ALU_DIV_EN
            S_DIV: begin
                rem_d = w_rem_next;
                quo_d = w_quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == c_LAST) begin
                    result_d = {w_rem_next, w_quo_next};
                    carry_d  = 1'b0;
                    err_d    = divz_q;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
`ifdef CALC_ALU_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
            dsor_q   <= '0;
            divz_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
`ifdef CALC_ALU_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsor_q   <= dsor_d;
            divz_q   <= divz_d;
`endif
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign number_out = result_q;
    assign carry      = carry_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_alu_seq
// Purpose  : Directed self-checking bench for calc_alu_seq (WIDTH=4 and
//            WIDTH=8 instances). Divide checks follow CALC_ALU_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_alu_seq;

    logic        clk;
    logic        clear_n;

    logic        start4;
    logic [1:0]  op4;
    logic [3:0]  a4, b4;
    logic        busy4, done4, carry4, err4;
    logic [7:0]  out4;

    logic        start8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, carry8, err8;
    logic [15:0] out8;

    int n_cmp;
    int n_bad;

    // Observation vectors: {busy, done, carry, err, number_out}
    logic [11:0] obs4;
    logic [19:0] obs8;
    assign obs4 = {busy4, done4, carry4, err4, out4};
    assign obs8 = {busy8, done8, carry8, err8, out8};

    calc_alu_seq #(.WIDTH(4)) dut4 (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start4),
        .op_sel     (op4),
        .num1       (a4),
        .num2       (b4),
        .busy       (busy4),
        .done       (done4),
        .number_out (out4),
        .carry      (carry4),
        .err        (err4)
    );

    calc_alu_seq #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start8),
        .op_sel     (op8),
        .num1       (a8),
        .num2       (b8),
        .busy       (busy8),
        .done       (done8),
        .number_out (out8),
        .carry      (carry8),
        .err        (err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: apply inputs on the falling edge
    task automatic drive4(input logic s, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        start4 = s;
        op4    = op;
        a4     = a;
        b4     = b;
    endtask

    // Advance past the next rising edge and settle before sampling
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        clear_n = 1'b0;
        start4 = 1'b0; op4 = 2'b00; a4 = '0; b4 = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        #12;
        n_cmp++;
        if (obs4 !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_w4: got %h want %h", obs4, 12'h000);
        end
        n_cmp++;
        if (obs8 !== 20'h00000) begin
            n_bad++;
            $display("FAIL reset_w8: got %h want %h", obs8, 20'h00000);
        end
        @(negedge clk);
        clear_n = 1'b1;
    endtask

    task automatic test_add;
        drive4(1'b1, 2'b00, 4'd9, 4'd8);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h11}) begin
            n_bad++;
            $display("FAIL add_9_8: got %h want %h", obs4, {1'b0, 1'b1, 1'b1, 1'b0, 8'h11});
        end
    endtask

    task automatic test_back_to_back;
        // Issued in the done cycle of the previous add
        drive4(1'b1, 2'b00, 4'd3, 4'd4);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h07}) begin
            n_bad++;
            $display("FAIL add_b2b_3_4: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b0, 8'h07});
        end
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h07}) begin
            n_bad++;
            $display("FAIL done_drop_hold: got %h want %h", obs4, {1'b0, 1'b0, 1'b0, 1'b0, 8'h07});
        end
    endtask

    task automatic test_sub;
        drive4(1'b1, 2'b01, 4'd3, 4'd5);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h1E}) begin
            n_bad++;
            $display("FAIL sub_3_5: got %h want %h", obs4, {1'b0, 1'b1, 1'b1, 1'b0, 8'h1E});
        end
        drive4(1'b1, 2'b01, 4'd5, 4'd3);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h02}) begin
            n_bad++;
            $display("FAIL sub_5_3: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b0, 8'h02});
        end
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick();
    endtask

    task automatic test_mul;
        drive4(1'b1, 2'b10, 4'd15, 4'd15);
        tick();
        n_cmp++;
        if (obs4 !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h02}) begin
            n_bad++;
            $display("FAIL mul_accept: got %h want %h", obs4, {1'b1, 1'b0, 1'b0, 1'b0, 8'h02});
        end
        // Starts with other operands while busy must be ignored
        for (int i = 1; i <= 3; i++) begin
            drive4(1'b1, 2'b00, 4'd1, 4'd1);
            tick();
            n_cmp++;
            if (obs4 !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h02}) begin
                n_bad++;
                $display("FAIL mul_busy_cyc%0d: got %h want %h", i, obs4, {1'b1, 1'b0, 1'b0, 1'b0, 8'h02});
            end
        end
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b0, 8'hE1}) begin
            n_bad++;
            $display("FAIL mul_15_15: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b0, 8'hE1});
        end
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b0, 1'b0, 1'b0, 8'hE1}) begin
            n_bad++;
            $display("FAIL mul_hold: got %h want %h", obs4, {1'b0, 1'b0, 1'b0, 1'b0, 8'hE1});
        end
    endtask

    task automatic test_clear_abort;
        int seen_done;
        drive4(1'b1, 2'b10, 4'd7, 4'd6);
        tick();
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick();
        tick();
        // Asynchronous clear between edges
        #2;
        clear_n = 1'b0;
        #1;
        n_cmp++;
        if (obs4 !== 12'h000) begin
            n_bad++;
            $display("FAIL clear_async: got %h want %h", obs4, 12'h000);
        end
        @(negedge clk);
        clear_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done4 === 1'b1) seen_done++;
        end
        n_cmp++;
        if (seen_done !== 0) begin
            n_bad++;
            $display("FAIL clear_no_done: got %0d done pulses want 0", seen_done);
        end
        drive4(1'b1, 2'b10, 4'd2, 4'd3);
        tick();
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (done4 !== 1'b0) begin
                n_bad++;
                $display("FAIL mul_2_3_early_done_edge%0d: got %b want 0", i, done4);
            end
        end
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h06}) begin
            n_bad++;
            $display("FAIL mul_2_3: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b0, 8'h06});
        end
    endtask

    task automatic test_div;
`ifdef CALC_ALU_DIV_EN
        drive4(1'b1, 2'b11, 4'd13, 4'd4);
        tick();
        n_cmp++;
        if (busy4 !== 1'b1) begin
            n_bad++;
            $display("FAIL div_busy: got %b want 1", busy4);
        end
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick(); tick(); tick();
        n_cmp++;
        if (done4 !== 1'b0) begin
            n_bad++;
            $display("FAIL div_early_done: got %b want 0", done4);
        end
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h13}) begin
            n_bad++;
            $display("FAIL div_13_4: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b0, 8'h13});
        end
        drive4(1'b1, 2'b11, 4'd9, 4'd0);
        tick();
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick(); tick(); tick(); tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h9F}) begin
            n_bad++;
            $display("FAIL div_9_0: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b1, 8'h9F});
        end
`else
        drive4(1'b1, 2'b11, 4'd13, 4'd4);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b1, 8'h00}) begin
            n_bad++;
            $display("FAIL op11_illegal: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b1, 8'h00});
        end
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick();
`endif
        // A following add clears err
        drive4(1'b1, 2'b00, 4'd1, 4'd1);
        tick();
        n_cmp++;
        if (obs4 !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h02}) begin
            n_bad++;
            $display("FAIL err_cleared: got %h want %h", obs4, {1'b0, 1'b1, 1'b0, 1'b0, 8'h02});
        end
        drive4(1'b0, 2'b00, 4'd0, 4'd0);
        tick();
    endtask

    task automatic test_mul_w8;
        @(negedge clk);
        start8 = 1'b1; op8 = 2'b10; a8 = 8'd255; b8 = 8'd255;
        tick();
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            n_cmp++;
            if ({busy8, done8} !== 2'b10) begin
                n_bad++;
                $display("FAIL mul8_busy_edge%0d: got %b want 10", i, {busy8, done8});
            end
        end
        tick();
        n_cmp++;
        if (obs8 !== {1'b0, 1'b1, 1'b0, 1'b0, 16'hFE01}) begin
            n_bad++;
            $display("FAIL mul8_255_255: got %h want %h", obs8, {1'b0, 1'b1, 1'b0, 1'b0, 16'hFE01});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_add();
        test_back_to_back();
        test_sub();
        test_mul();
        test_clear_abort();
        test_div();
        test_mul_w8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
